// File: rtl/plab5_mcore_dma_burst_controller.sv
// ---------------------------------------------------------------------------
// plab5_mcore_dma_burst_controller
//
// Multi-channel DMA copy engine. Each channel accepts a command holding a
// source byte address, a destination byte address, a word count and a
// security domain. Pending channels are served one at a time in round-robin
// order. Every word is moved by a read request, a wait for its response, a
// write request and a wait for the write acknowledge. A channel raises a
// one-cycle done pulse when its transfer ends.
//
// Ports
//   clk, reset          : clock, asynchronous active-low reset
//   cmd_val/cmd_rdy     : per-channel command handshake
//   cmd_src/cmd_dest    : per-channel byte addresses (channel i in slice i)
//   cmd_len             : per-channel word count
//   cmd_domain          : per-channel security domain
//   done_val            : per-channel completion pulse
//   mem_req_*           : memory request (type 0 = read, 1 = write)
//   mem_resp_*          : memory response (read data or write acknowledge)
// ---------------------------------------------------------------------------
module plab5_mcore_dma_burst_controller #(
    parameter int p_addr_nbits = 32,
    parameter int p_data_nbits = 32,
    parameter int p_len_nbits  = 8,
    parameter int p_num_chan   = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [p_num_chan-1:0]              cmd_val,
    output logic [p_num_chan-1:0]              cmd_rdy,
    input  logic [p_num_chan*p_addr_nbits-1:0] cmd_src,
    input  logic [p_num_chan*p_addr_nbits-1:0] cmd_dest,
    input  logic [p_num_chan*p_len_nbits-1:0]  cmd_len,
    input  logic [p_num_chan-1:0]              cmd_domain,
    output logic [p_num_chan-1:0]              done_val,
    output logic                               mem_req_val,
    input  logic                               mem_req_rdy,
    output logic [2:0]                         mem_req_type,
    output logic [p_addr_nbits-1:0]            mem_req_addr,
    output logic [p_data_nbits-1:0]            mem_req_data,
    output logic                               mem_req_domain,
    input  logic                               mem_resp_val,
    output logic                               mem_resp_rdy,
    input  logic [p_data_nbits-1:0]            mem_resp_data
);

    localparam int CW = $clog2(p_num_chan);
    localparam int SW = CW + 1;
    localparam logic [p_addr_nbits-1:0] BYTES = p_addr_nbits'(p_data_nbits / 8);

    typedef enum logic [2:0] {
        IDLE, ARB, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [p_num_chan-1:0]   pending_q, pending_d;
    logic [CW-1:0]           ptr_q, ptr_d;
    logic [CW-1:0]           grant_q, grant_d;
    logic [p_addr_nbits-1:0] src_q, src_d;
    logic [p_addr_nbits-1:0] dest_q, dest_d;
    logic [p_len_nbits-1:0]  rem_q, rem_d;
    logic [p_data_nbits-1:0] word_q, word_d;
    logic                    dom_q, dom_d;

    logic [p_addr_nbits-1:0] ch_src_q  [p_num_chan];
    logic [p_addr_nbits-1:0] ch_dest_q [p_num_chan];
    logic [p_len_nbits-1:0]  ch_len_q  [p_num_chan];
    logic [p_num_chan-1:0]   ch_dom_q;

    logic [p_num_chan-1:0]   accept;
    logic                    arb_found;
    logic [CW-1:0]           arb_sel;
    logic [SW-1:0]           rr_sum;

    // A channel can take a new command unless it is already queued or being
    // served; the active channel keeps its pending bit until DONE, so the
    // pending vector alone covers both cases. Held low during reset.
    always_comb begin
        cmd_rdy = '0;
        if (reset) begin
            cmd_rdy = (state_q == IDLE) ? '1 : ~pending_q;
        end
    end

    assign accept = cmd_val & cmd_rdy;

    // Round-robin search: scan the channels starting one past the last grant,
    // wrapping modulo the channel count.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        rr_sum    = '0;
        for (int i = 1; i <= p_num_chan; i++) begin
            rr_sum = {1'b0, ptr_q} + SW'(i);
            if (rr_sum >= SW'(p_num_chan)) begin
                rr_sum = rr_sum - SW'(p_num_chan);
            end
            if (!arb_found && pending_q[rr_sum[CW-1:0]]) begin
                arb_found = 1'b1;
                arb_sel   = rr_sum[CW-1:0];
            end
        end
    end

    // Per-channel command registers, loaded whenever that channel's command
    // is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < p_num_chan; i++) begin
                ch_src_q[i]  <= '0;
                ch_dest_q[i] <= '0;
                ch_len_q[i]  <= '0;
            end
            ch_dom_q <= '0;
        end else begin
            for (int i = 0; i < p_num_chan; i++) begin
                if (accept[i]) begin
                    ch_src_q[i]  <= cmd_src[i*p_addr_nbits +: p_addr_nbits];
                    ch_dest_q[i] <= cmd_dest[i*p_addr_nbits +: p_addr_nbits];
                    ch_len_q[i]  <= cmd_len[i*p_len_nbits +: p_len_nbits];
                    ch_dom_q[i]  <= cmd_domain[i];
                end
            end
        end
    end

    // Transfer engine state and working copies of the granted command.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            ptr_q     <= CW'(p_num_chan - 1);
            grant_q   <= '0;
            src_q     <= '0;
            dest_q    <= '0;
            rem_q     <= '0;
            word_q    <= '0;
            dom_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            src_q     <= src_d;
            dest_q    <= dest_d;
            rem_q     <= rem_d;
            word_q    <= word_d;
            dom_q     <= dom_d;
        end
    end

    // Next-state and output decode. The request address switches between
    // source and destination only by state, and the write data is the word
    // register, so both stay put while a request is stalled.
    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q | accept;
        ptr_d          = ptr_q;
        grant_d        = grant_q;
        src_d          = src_q;
        dest_d         = dest_q;
        rem_d          = rem_q;
        word_d         = word_q;
        dom_d          = dom_q;
        done_val       = '0;
        mem_req_val    = 1'b0;
        mem_req_type   = 3'd0;
        mem_req_addr   = dest_q;
        mem_req_data   = word_q;
        mem_req_domain = dom_q;
        mem_resp_rdy   = 1'b0;

        case (state_q)
            IDLE: begin
                mem_req_domain = 1'b0;
                if ((|pending_q) || (|accept)) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                mem_req_domain = ch_dom_q[arb_sel];
                if (arb_found) begin
                    grant_d = arb_sel;
                    ptr_d   = arb_sel;
                    src_d   = ch_src_q[arb_sel];
                    dest_d  = ch_dest_q[arb_sel];
                    rem_d   = ch_len_q[arb_sel];
                    dom_d   = ch_dom_q[arb_sel];
                    state_d = (ch_len_q[arb_sel] == '0) ? DONE : RD_REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_REQ: begin
                mem_req_val  = 1'b1;
                mem_req_addr = src_q;
                if (mem_req_rdy) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                mem_resp_rdy = 1'b1;
                if (mem_resp_val) begin
                    word_d  = mem_resp_data;
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                mem_req_val  = 1'b1;
                mem_req_type = 3'd1;
                if (mem_req_rdy) begin
                    state_d = WR_WAIT;
                end
            end
            WR_WAIT: begin
                mem_resp_rdy = 1'b1;
                if (mem_resp_val) begin
                    src_d   = src_q + BYTES;
                    dest_d  = dest_q + BYTES;
                    rem_d   = rem_q - p_len_nbits'(1);
                    state_d = (rem_q == p_len_nbits'(1)) ? DONE : RD_REQ;
                end
            end
            DONE: begin
                done_val[grant_q]  = 1'b1;
                pending_d[grant_q] = 1'b0;
                state_d = (|pending_d) ? ARB : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_plab5_mcore_dma_burst_controller.sv
// ---------------------------------------------------------------------------
// tb_plab5_mcore_dma_burst_controller
//
// Bench for the two-channel DMA burst controller. A memory responder answers
// every request one cycle after its handshake (optionally stalling writes),
// logs each request and each done pulse. Scenarios build the expected
// request stream and done-pulse cycles from the command list: grant order
// is decided by scanning channels after the last one served, each word is a
// read of src+4k followed by a write of dest+4k carrying the memory contents
// of the read address, and a transfer ends 2 + len*(4 + write stall) cycles
// after the previous one started arbitration.
// ---------------------------------------------------------------------------
module tb_plab5_mcore_dma_burst_controller;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int NC = 2;

    logic              clk;
    logic              reset;
    logic [NC-1:0]     cmd_val;
    logic [NC-1:0]     cmd_rdy;
    logic [NC*AW-1:0]  cmd_src;
    logic [NC*AW-1:0]  cmd_dest;
    logic [NC*LW-1:0]  cmd_len;
    logic [NC-1:0]     cmd_domain;
    logic [NC-1:0]     done_val;
    logic              mem_req_val;
    logic              mem_req_rdy;
    logic [2:0]        mem_req_type;
    logic [AW-1:0]     mem_req_addr;
    logic [DW-1:0]     mem_req_data;
    logic              mem_req_domain;
    logic              mem_resp_val;
    logic              mem_resp_rdy;
    logic [DW-1:0]     mem_resp_data;

    typedef struct packed {
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] data;
        logic        dom;
    } op_t;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [NC-1:0] val;
    } done_t;

    op_t         reqQ[$];
    op_t         expQ[$];
    done_t       doneQ[$];
    done_t       expDoneQ[$];

    int          numChecks;
    int          numFails;
    int          cycleCount;
    int          wrStall;
    int          lastCh;
    logic [31:0] memSeed;
    logic [31:0] chSrc  [NC];
    logic [31:0] chDest [NC];
    int          chLen  [NC];
    logic        chDom  [NC];

    plab5_mcore_dma_burst_controller #(
        .p_addr_nbits (AW),
        .p_data_nbits (DW),
        .p_len_nbits  (LW),
        .p_num_chan   (NC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_val        (cmd_val),
        .cmd_rdy        (cmd_rdy),
        .cmd_src        (cmd_src),
        .cmd_dest       (cmd_dest),
        .cmd_len        (cmd_len),
        .cmd_domain     (cmd_domain),
        .done_val       (done_val),
        .mem_req_val    (mem_req_val),
        .mem_req_rdy    (mem_req_rdy),
        .mem_req_type   (mem_req_type),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_domain (mem_req_domain),
        .mem_resp_val   (mem_resp_val),
        .mem_resp_rdy   (mem_resp_rdy),
        .mem_resp_data  (mem_resp_data)
    );

    // Free-running clock and a count of rising edges seen so far.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cycleCount = 0;
        forever begin
            @(posedge clk);
            cycleCount++;
        end
    end

    // Memory contents are a fixed scramble of the address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ memSeed;
    endfunction

    // Memory responder: grants a request at the negedge it is seen (writes
    // may be held off wrStall cycles) and answers on the following cycle.
    initial begin
        logic        respPend;
        logic [31:0] respData;
        int          stallCnt;
        logic [31:0] heldAddr;
        logic [31:0] heldData;
        respPend      = 1'b0;
        respData      = '0;
        stallCnt      = 0;
        heldAddr      = '0;
        heldData      = '0;
        mem_req_rdy   = 1'b0;
        mem_resp_val  = 1'b0;
        mem_resp_data = '0;
        forever begin
            @(negedge clk);
            if (done_val !== '0) begin
                doneQ.push_back('{cyc: 32'(cycleCount), val: done_val});
            end
            mem_resp_val  = respPend;
            mem_resp_data = respData;
            if (respPend) begin
                numChecks++;
                if (mem_resp_rdy !== 1'b1) begin
                    numFails++;
                    $display("[TB] FAIL resp_rdy_in_wait: got %b required 1", mem_resp_rdy);
                end
            end
            respPend    = 1'b0;
            mem_req_rdy = 1'b0;
            if (reset !== 1'b1) begin
                stallCnt     = 0;
                mem_resp_val = 1'b0;
            end else if (mem_req_val === 1'b1) begin
                if (stallCnt > 0) begin
                    numChecks++;
                    if ({mem_req_addr, mem_req_data} !== {heldAddr, heldData}) begin
                        numFails++;
                        $display("[TB] FAIL stall_hold: got %h/%h required %h/%h",
                                 mem_req_addr, mem_req_data, heldAddr, heldData);
                    end
                end
                if (mem_req_type == 3'd1 && stallCnt < wrStall) begin
                    if (stallCnt == 0) begin
                        heldAddr = mem_req_addr;
                        heldData = mem_req_data;
                    end
                    stallCnt++;
                end else begin
                    stallCnt    = 0;
                    mem_req_rdy = 1'b1;
                    reqQ.push_back('{typ: mem_req_type, addr: mem_req_addr,
                                     data: (mem_req_type == 3'd0) ? 32'd0 : mem_req_data,
                                     dom: mem_req_domain});
                    respPend = 1'b1;
                    respData = (mem_req_type == 3'd0) ? memWord(mem_req_addr) : 32'd0;
                end
            end
        end
    end

    // Reference model: next channel served, and the traffic of one transfer.
    function automatic int nextGrant(input logic [NC-1:0] pend);
        for (int i = 1; i <= NC; i++) begin
            if (pend[(lastCh + i) % NC]) return (lastCh + i) % NC;
        end
        return 0;
    endfunction

    function automatic void modelTransfer(input int ch);
        logic [31:0] a;
        for (int k = 0; k < chLen[ch]; k++) begin
            a = chSrc[ch] + 32'(4 * k);
            expQ.push_back('{typ: 3'd0, addr: a, data: 32'd0, dom: chDom[ch]});
            expQ.push_back('{typ: 3'd1, addr: chDest[ch] + 32'(4 * k),
                             data: memWord(a), dom: chDom[ch]});
        end
        lastCh = ch;
    endfunction

    task automatic set_chan(input int ch, input logic [31:0] src, input logic [31:0] dest,
                            input int len, input logic dom);
        chSrc[ch]  = src;
        chDest[ch] = dest;
        chLen[ch]  = len;
        chDom[ch]  = dom;
        cmd_src[ch*AW +: AW]  = src;
        cmd_dest[ch*AW +: AW] = dest;
        cmd_len[ch*LW +: LW]  = LW'(len);
        cmd_domain[ch]        = dom;
    endtask

    // Issues the commands in mask in one IDLE cycle, builds the expectation
    // and waits (bounded) for the expected number of done pulses.
    task automatic do_batch(input logic [NC-1:0] mask, input int budget);
        logic [NC-1:0] pend;
        logic [NC-1:0] oneHot;
        int            base;
        int            g;
        reqQ.delete();
        expQ.delete();
        doneQ.delete();
        expDoneQ.delete();
        @(negedge clk);
        cmd_val = mask;
        base    = cycleCount;
        numChecks++;
        if ((cmd_rdy & mask) !== mask) begin
            numFails++;
            $display("[TB] FAIL batch_cmd_rdy: got %b required %b", cmd_rdy & mask, mask);
        end
        pend = mask;
        while (pend != '0) begin
            g = nextGrant(pend);
            modelTransfer(g);
            base      = base + 2 + chLen[g] * (4 + wrStall);
            oneHot    = '0;
            oneHot[g] = 1'b1;
            expDoneQ.push_back('{cyc: 32'(base), val: oneHot});
            pend[g] = 1'b0;
        end
        @(negedge clk);
        cmd_val = '0;
        for (int c = 0; c < budget && doneQ.size() < expDoneQ.size(); c++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        cmd_val = '0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        lastCh = NC - 1;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        cmd_val = '1;
        repeat (2) @(negedge clk);
        numChecks++;
        if (cmd_rdy !== '0) begin
            numFails++;
            $display("[TB] FAIL reset_cmd_rdy: got %b required 00", cmd_rdy);
        end
        numChecks++;
        if ({mem_req_val, mem_resp_rdy, mem_req_domain, done_val} !== '0) begin
            numFails++;
            $display("[TB] FAIL reset_outputs: got %b required 0", {mem_req_val, mem_resp_rdy, mem_req_domain, done_val});
        end
        cmd_val = '0;
        #2 reset = 1'b1;
        #1;
        numChecks++;
        if (cmd_rdy !== '1) begin
            numFails++;
            $display("[TB] FAIL release_cmd_rdy: got %b required 11", cmd_rdy);
        end
        @(negedge clk);
        numChecks++;
        if ({cmd_rdy, mem_req_val, done_val} !== {2'b11, 1'b0, 2'b00}) begin
            numFails++;
            $display("[TB] FAIL idle_after_release: got %b required 11000", {cmd_rdy, mem_req_val, done_val});
        end
        lastCh = NC - 1;
    endtask

    task automatic test_single_burst();
        wrStall = 0;
        set_chan(0, 32'h100, 32'h200, 3, 1'($urandom));
        do_batch(2'b01, 100);
        numChecks++;
        if (reqQ.size() != expQ.size()) begin
            numFails++;
            $display("[TB] FAIL single_op_count: got %0d required %0d", reqQ.size(), expQ.size());
        end
        for (int i = 0; i < expQ.size() && i < reqQ.size(); i++) begin
            numChecks++;
            if (reqQ[i] !== expQ[i]) begin
                numFails++;
                $display("[TB] FAIL single_op%0d: got %h required %h", i, reqQ[i], expQ[i]);
            end
        end
        numChecks++;
        if (doneQ.size() != 1 || doneQ[0] !== expDoneQ[0]) begin
            numFails++;
            $display("[TB] FAIL single_done: got %0d pulses first %h required %h", doneQ.size(),
                     (doneQ.size() > 0) ? doneQ[0] : '0, expDoneQ[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [NC-1:0] masks [3];
        masks[0] = 2'b11;
        masks[1] = 2'b01;
        masks[2] = 2'b11;
        wrStall = 0;
        apply_reset();
        for (int r = 0; r < 3; r++) begin
            set_chan(0, 32'h1000 + 32'(r * 64), 32'h2000 + 32'(r * 64), 1 + r, 1'b0);
            set_chan(1, 32'h5000 + 32'(r * 64), 32'h6000 + 32'(r * 64), 2, 1'b1);
            do_batch(masks[r], 200);
            numChecks++;
            if (reqQ.size() != expQ.size()) begin
                numFails++;
                $display("[TB] FAIL b2b%0d_op_count: got %0d required %0d", r, reqQ.size(), expQ.size());
            end
            for (int i = 0; i < expQ.size() && i < reqQ.size(); i++) begin
                numChecks++;
                if (reqQ[i] !== expQ[i]) begin
                    numFails++;
                    $display("[TB] FAIL b2b%0d_op%0d: got %h required %h", r, i, reqQ[i], expQ[i]);
                end
            end
            numChecks++;
            if (doneQ.size() != expDoneQ.size()) begin
                numFails++;
                $display("[TB] FAIL b2b%0d_done_count: got %0d required %0d", r, doneQ.size(), expDoneQ.size());
            end
            for (int i = 0; i < expDoneQ.size() && i < doneQ.size(); i++) begin
                numChecks++;
                if (doneQ[i] !== expDoneQ[i]) begin
                    numFails++;
                    $display("[TB] FAIL b2b%0d_done%0d: got %h required %h", r, i, doneQ[i], expDoneQ[i]);
                end
            end
        end
    endtask

    task automatic test_zero_len();
        wrStall = 0;
        set_chan(1, 32'h3000, 32'h4000, 0, 1'b1);
        do_batch(2'b10, 20);
        numChecks++;
        if (reqQ.size() != 0) begin
            numFails++;
            $display("[TB] FAIL zero_len_traffic: got %0d requests required 0", reqQ.size());
        end
        numChecks++;
        if (doneQ.size() != 1 || doneQ[0] !== expDoneQ[0]) begin
            numFails++;
            $display("[TB] FAIL zero_len_done: got %0d pulses first %h required %h", doneQ.size(),
                     (doneQ.size() > 0) ? doneQ[0] : '0, expDoneQ[0]);
        end
    endtask

    task automatic test_write_stall();
        wrStall = 5;
        set_chan(1, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, 2, 1'($urandom));
        do_batch(2'b10, 100);
        numChecks++;
        if (reqQ.size() != expQ.size()) begin
            numFails++;
            $display("[TB] FAIL stall_op_count: got %0d required %0d", reqQ.size(), expQ.size());
        end
        for (int i = 0; i < expQ.size() && i < reqQ.size(); i++) begin
            numChecks++;
            if (reqQ[i] !== expQ[i]) begin
                numFails++;
                $display("[TB] FAIL stall_op%0d: got %h required %h", i, reqQ[i], expQ[i]);
            end
        end
        numChecks++;
        if (doneQ.size() != 1 || doneQ[0] !== expDoneQ[0]) begin
            numFails++;
            $display("[TB] FAIL stall_done: got %0d pulses first %h required %h", doneQ.size(),
                     (doneQ.size() > 0) ? doneQ[0] : '0, expDoneQ[0]);
        end
        wrStall = 0;
    endtask

    task automatic test_addr_wrap();
        wrStall = 0;
        set_chan(0, 32'hFFFF_FFFC, 32'h0000_7000, 2, 1'b0);
        do_batch(2'b01, 100);
        numChecks++;
        if (reqQ.size() < 3 || reqQ[2].addr !== 32'h0 || reqQ[2].typ !== 3'd0) begin
            numFails++;
            $display("[TB] FAIL wrap_second_read: got %h required read of 00000000",
                     (reqQ.size() > 2) ? reqQ[2] : '0);
        end
        for (int i = 0; i < expQ.size() && i < reqQ.size(); i++) begin
            numChecks++;
            if (reqQ[i] !== expQ[i]) begin
                numFails++;
                $display("[TB] FAIL wrap_op%0d: got %h required %h", i, reqQ[i], expQ[i]);
            end
        end
    endtask

    task automatic test_random_bursts();
        logic [NC-1:0] mask;
        for (int r = 0; r < 8; r++) begin
            wrStall = $urandom_range(0, 3);
            for (int c = 0; c < NC; c++) begin
                set_chan(c, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                         $urandom_range(0, 4), 1'($urandom));
            end
            mask = NC'($urandom_range(1, 3));
            do_batch(mask, 300);
            numChecks++;
            if (reqQ.size() != expQ.size()) begin
                numFails++;
                $display("[TB] FAIL rand%0d_op_count: got %0d required %0d", r, reqQ.size(), expQ.size());
            end
            for (int i = 0; i < expQ.size() && i < reqQ.size(); i++) begin
                numChecks++;
                if (reqQ[i] !== expQ[i]) begin
                    numFails++;
                    $display("[TB] FAIL rand%0d_op%0d: got %h required %h", r, i, reqQ[i], expQ[i]);
                end
            end
            numChecks++;
            if (doneQ.size() != expDoneQ.size()) begin
                numFails++;
                $display("[TB] FAIL rand%0d_done_count: got %0d required %0d", r, doneQ.size(), expDoneQ.size());
            end
            for (int i = 0; i < expDoneQ.size() && i < doneQ.size(); i++) begin
                numChecks++;
                if (doneQ[i] !== expDoneQ[i]) begin
                    numFails++;
                    $display("[TB] FAIL rand%0d_done%0d: got %h required %h", r, i, doneQ[i], expDoneQ[i]);
                end
            end
        end
        wrStall = 0;
    endtask

    task automatic test_reset_midtransfer();
        int waited;
        int donesBefore;
        wrStall = 0;
        set_chan(0, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, 3, 1'b1);
        @(negedge clk);
        cmd_val = 2'b01;
        @(negedge clk);
        cmd_val = '0;
        waited  = 0;
        while (mem_resp_rdy !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        numChecks++;
        if (mem_resp_rdy !== 1'b1) begin
            numFails++;
            $display("[TB] FAIL midreset_reach_wait: got %b required 1 within 20 cycles", mem_resp_rdy);
        end
        donesBefore = doneQ.size();
        #2 reset = 1'b0;
        #1;
        numChecks++;
        if ({mem_req_val, mem_resp_rdy, mem_req_domain, done_val, cmd_rdy} !== '0) begin
            numFails++;
            $display("[TB] FAIL midreset_outputs: got %b required 0",
                     {mem_req_val, mem_resp_rdy, mem_req_domain, done_val, cmd_rdy});
        end
        repeat (3) @(negedge clk);
        numChecks++;
        if (doneQ.size() != donesBefore) begin
            numFails++;
            $display("[TB] FAIL midreset_no_done: got %0d pulses required %0d", doneQ.size(), donesBefore);
        end
        #2 reset = 1'b1;
        lastCh = NC - 1;
        set_chan(1, 32'h0000_8000, 32'h0000_9000, 2, 1'b0);
        do_batch(2'b10, 100);
        numChecks++;
        if (reqQ.size() != expQ.size()) begin
            numFails++;
            $display("[TB] FAIL midreset_after_op_count: got %0d required %0d", reqQ.size(), expQ.size());
        end
        for (int i = 0; i < expQ.size() && i < reqQ.size(); i++) begin
            numChecks++;
            if (reqQ[i] !== expQ[i]) begin
                numFails++;
                $display("[TB] FAIL midreset_after_op%0d: got %h required %h", i, reqQ[i], expQ[i]);
            end
        end
        numChecks++;
        if (doneQ.size() != 1 || doneQ[0] !== expDoneQ[0]) begin
            numFails++;
            $display("[TB] FAIL midreset_after_done: got %0d pulses first %h required %h", doneQ.size(),
                     (doneQ.size() > 0) ? doneQ[0] : '0, expDoneQ[0]);
        end
    endtask

    // Scenario sequence.
    initial begin
        numChecks  = 0;
        numFails   = 0;
        wrStall    = 0;
        lastCh     = NC - 1;
        memSeed    = $urandom;
        reset      = 1'b0;
        cmd_val    = '0;
        cmd_src    = '0;
        cmd_dest   = '0;
        cmd_len    = '0;
        cmd_domain = '0;
        for (int c = 0; c < NC; c++) begin
            chSrc[c]  = '0;
            chDest[c] = '0;
            chLen[c]  = 0;
            chDom[c]  = 1'b0;
        end
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_zero_len();
        test_write_stall();
        test_addr_wrap();
        test_random_bursts();
        test_reset_midtransfer();
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
